// File: rtl/fprnd_arbiter_if.sv
// Request/result bus between the FP producers, the rounder arbiter and the
// writeback consumer. Producers and the consumer sit on the master side and
// the arbiter sits on the slave side.
interface fprnd_if #(
  parameter int N    = 2,
  parameter int IN_W = 126,
  parameter int ID_W = $clog2(N)
) ();
  logic [N-1:0]      req_valid;
  logic [N*IN_W-1:0] req_data;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [63:0]       out_fp;
  logic [4:0]        out_ieee;
  logic [ID_W-1:0]   out_id;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_fp, out_ieee, out_id
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_fp, out_ieee, out_id
  );
endinterface

// File: rtl/fprnd_arbiter.sv
// fprnd_arbiter: round-robin share of one special-case rounder/packer among
// N FP producers. Stage 1 registers the winning request bundle (plus the trap
// enables current at grant time) to drive the rounder; stage 2 registers the
// rounder result with the requester tag. Also holds the sticky IEEE flags.
// Optional feature macro: FPRND_TRAP_EN adds trap_mask/trap (registered trap
// whenever a masked sticky flag is set).
module fprnd_arbiter #(
  parameter int N    = 2,
  parameter int IN_W = 126,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  fprnd_if.slave          bus,
  input  logic            cfg_we,
  input  logic [1:0]      cfg_wdata,
  output logic [IN_W-1:0] rnd_bundle,
  output logic            rnd_ovfen,
  output logic            rnd_unfen,
  input  logic [63:0]     rnd_fp,
  input  logic [4:0]      rnd_ieee,
  output logic [4:0]      flags,
  input  logic            flags_clr
`ifdef FPRND_TRAP_EN
  ,
  input  logic [4:0]      trap_mask,
  output logic            trap
`endif
);

  logic            vld_p1, vld_p2;
  logic [IN_W-1:0] bundle_p1;
  logic [ID_W-1:0] id_p1, id_p2;
  logic            ovfen_p1, unfen_p1;
  logic [63:0]     fp_p2;
  logic [4:0]      ieee_p2;
  logic [ID_W-1:0] ptr;
  logic            cfg_ovfen, cfg_unfen;
  logic            s1_en, s2_en, cap_p2;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  logic [IN_W-1:0] gnt_data;
  logic [4:0]      flags_next;

  // Index k positions after base, wrapping at N so unused codes are skipped.
  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int k);
    int t;
    t = int'(base) + k;
    if (t >= N) t = t - N;
    return t[ID_W-1:0];
  endfunction

  assign s2_en  = !vld_p2 || bus.out_ready;
  assign s1_en  = !vld_p1 || s2_en;
  assign cap_p2 = s2_en && vld_p1;

  // Round-robin grant: first valid requester after the pointer, only when S1 can accept.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    if (s1_en) begin
      for (int k = 1; k <= N; k++) begin
        if (!gnt_any && bus.req_valid[rr_idx(ptr, k)]) begin
          gnt[rr_idx(ptr, k)] = 1'b1;
          gnt_id              = rr_idx(ptr, k);
          gnt_any             = 1'b1;
        end
      end
    end
  end

  assign gnt_data      = bus.req_data[int'(gnt_id)*IN_W +: IN_W];
  assign bus.req_ready = gnt;

  // Trap-enable configuration; a write lands after any same-cycle grant has sampled the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_ovfen <= 1'b0;
      cfg_unfen <= 1'b0;
    end else if (cfg_we) begin
      {cfg_ovfen, cfg_unfen} <= cfg_wdata;
    end
  end

  // ---- stage 1: capture granted bundle, tag and trap enables; advance RR pointer ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
      id_p1     <= '0;
      ovfen_p1  <= 1'b0;
      unfen_p1  <= 1'b0;
      ptr       <= ID_W'(N - 1);
    end else if (gnt_any) begin
      vld_p1    <= 1'b1;
      bundle_p1 <= gnt_data;
      id_p1     <= gnt_id;
      ovfen_p1  <= cfg_ovfen;
      unfen_p1  <= cfg_unfen;
      ptr       <= gnt_id;
    end else if (s2_en) begin
      vld_p1    <= 1'b0;
    end
  end

  assign rnd_bundle = bundle_p1;
  assign rnd_ovfen  = ovfen_p1;
  assign rnd_unfen  = unfen_p1;

  // ---- stage 2: capture rounder result with tag; hold under backpressure ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      fp_p2   <= '0;
      ieee_p2 <= '0;
      id_p2   <= '0;
    end else if (s2_en) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        fp_p2   <= rnd_fp;
        ieee_p2 <= rnd_ieee;
        id_p2   <= id_p1;
      end
    end
  end

  assign bus.out_valid = vld_p2;
  assign bus.out_fp    = fp_p2;
  assign bus.out_ieee  = ieee_p2;
  assign bus.out_id    = id_p2;

  // Sticky flag update: clear first, then OR in the op entering stage 2.
  always_comb begin
    flags_next = flags_clr ? 5'b0 : flags;
    if (cap_p2) flags_next = flags_next | rnd_ieee;
  end

  // Sticky flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flags <= '0;
    else     flags <= flags_next;
  end

`ifdef FPRND_TRAP_EN
  // Registered trap: any masked sticky flag set after this cycle's update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trap <= 1'b0;
    else     trap <= |(flags_next & trap_mask);
  end
`endif

endmodule

// File: tb/tb_fprnd_arbiter.sv
// Bench for fprnd_arbiter with N=3: directed scenarios plus randomized traffic.
// A queue-level reference model predicts grants, output timing and flags; a
// separate monitor compares every presented result against a scoreboard.
module tb_fprnd_arbiter;
  localparam int N    = 3;
  localparam int IN_W = 126;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fprnd_if #(.N(N), .IN_W(IN_W), .ID_W(ID_W)) bus ();

  logic            cfg_we;
  logic [1:0]      cfg_wdata;
  logic [IN_W-1:0] rnd_bundle;
  logic            rnd_ovfen, rnd_unfen;
  logic [63:0]     rnd_fp;
  logic [4:0]      rnd_ieee;
  logic [4:0]      flags;
  logic            flags_clr;
`ifdef FPRND_TRAP_EN
  logic [4:0]      trap_mask;
  logic            trap;
`endif

  // Stand-in rounder: result from the top 64 bundle bits, tweaked by the trap enables.
  assign rnd_fp   = rnd_bundle[IN_W-1 -: 64] ^ {62'd0, rnd_ovfen, rnd_unfen};
  assign rnd_ieee = rnd_bundle[4:0];

  fprnd_arbiter #(.N(N), .IN_W(IN_W), .ID_W(ID_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cfg_we     (cfg_we),
    .cfg_wdata  (cfg_wdata),
    .rnd_bundle (rnd_bundle),
    .rnd_ovfen  (rnd_ovfen),
    .rnd_unfen  (rnd_unfen),
    .rnd_fp     (rnd_fp),
    .rnd_ieee   (rnd_ieee),
    .flags      (flags),
    .flags_clr  (flags_clr)
`ifdef FPRND_TRAP_EN
    ,
    .trap_mask  (trap_mask),
    .trap       (trap)
`endif
  );

  typedef struct {
    logic [ID_W-1:0] id;
    logic [63:0]     fp;
    logic [4:0]      ieee;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int       m_ptr;
  logic     m_ovf, m_unf;
  logic [4:0] m_flags;
  int       mq[$];   // earliest presentation cycle of each in-flight op, oldest first
  int       cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [IN_W-1:0] rand_bundle();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[IN_W-1:0];
  endfunction

  task automatic rand_data();
    for (int i = 0; i < N; i++) bus.req_data[i*IN_W +: IN_W] = rand_bundle();
  endtask

  // One clock: predict and check at the falling edge, advance the model at the rising edge.
  task automatic step();
    logic exp_v, acc, consume;
    int g;
    logic [IN_W-1:0] d;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    exp_v = (mq.size() > 0) && (mq[0] <= cyc);
    chk("out_valid", 128'(bus.out_valid), 128'(exp_v));
    acc = (mq.size() < 2) || bus.out_ready;
    g = acc ? pick(bus.req_valid, m_ptr) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 128'(bus.req_ready), 128'(exp_rdy));
    if (mq.size() == 0) begin
      chk("flags", 128'(flags), 128'(m_flags));
`ifdef FPRND_TRAP_EN
      chk("trap", 128'(trap), 128'(|(m_flags & trap_mask)));
`endif
    end
    @(posedge clk);
    consume = exp_v && bus.out_ready;
    if (consume) begin
      void'(mq.pop_front());
      if (mq.size() > 0 && mq[0] < cyc + 1) mq[0] = cyc + 1;
    end
    if (g >= 0) begin
      d = bus.req_data[g*IN_W +: IN_W];
      sb.push_back('{id: g[ID_W-1:0], fp: d[IN_W-1 -: 64] ^ {62'd0, m_ovf, m_unf}, ieee: d[4:0]});
      mq.push_back(cyc + 2);
      m_flags = m_flags | d[4:0];
      m_ptr = g;
    end
    if (cfg_we) {m_ovf, m_unf} = cfg_wdata;
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rst = 1'b1;
    #3;
    chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
    chk("rst_flags", 128'(flags), 128'(0));
    chk("rst_out_fp", 128'(bus.out_fp), 128'(0));
    chk("rst_out_id", 128'(bus.out_id), 128'(0));
    chk("rst_bundle", 128'(rnd_bundle), 128'(0));
    sb.delete();
    mq.delete();
    m_ptr = N - 1;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_flags = '0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic single_op(input logic [4:0] ieee);
    logic [IN_W-1:0] b;
    b = rand_bundle();
    b[4:0] = ieee;
    bus.req_data[0 +: IN_W] = b;
    bus.req_valid = 3'b001;
    step();
    bus.req_valid = '0;
  endtask

  // Monitor: every presented result must match the oldest expected one.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected: got id %0d fp %0h with nothing expected", bus.out_id, bus.out_fp);
      end else begin
        chk("out_id", 128'(bus.out_id), 128'(sb[0].id));
        chk("out_fp", 128'(bus.out_fp), 128'(sb[0].fp));
        chk("out_ieee", 128'(bus.out_ieee), 128'(sb[0].ieee));
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_wdata = 2'b00;
    flags_clr = 1'b0;
`ifdef FPRND_TRAP_EN
    trap_mask = 5'b00001;
`endif
    do_reset();

    // single op from requester 0 (db=1, ZERO=1)
    bus.req_data[0 +: IN_W] = rand_bundle();
    bus.req_data[IN_W-1] = 1'b1;
    bus.req_data[7] = 1'b1;
    bus.req_valid = 3'b001;
    step();
    bus.req_valid = '0;
    repeat (3) step();

    // all requesters valid: rotation 0,1,2,0,1,2
    do_reset();
    bus.req_valid = 3'b111;
    repeat (6) begin rand_data(); step(); end
    bus.req_valid = '0;
    repeat (3) step();

    // backpressure: fill both stages, hold, then release
    bus.req_valid = 3'b111;
    bus.out_ready = 1'b0;
    repeat (5) begin rand_data(); step(); end
    bus.out_ready = 1'b1;
    repeat (6) begin rand_data(); step(); end
    bus.req_valid = '0;
    repeat (3) step();

    // sticky flags, then clear coinciding with a capture
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    m_flags = '0;
    single_op(5'b00001);
    repeat (3) step();
    single_op(5'b10000);
    repeat (3) step();
    chk("flags_sticky", 128'(flags), 128'(5'b10001));
    single_op(5'b00100);
    flags_clr = 1'b1;
    step();
    flags_clr = 1'b0;
    m_flags = 5'b00100;
    repeat (3) step();
    chk("flags_clr_set", 128'(flags), 128'(5'b00100));

    // cfg write in the grant cycle of op A applies only to op B
    bus.req_data[0 +: IN_W] = rand_bundle();
    bus.req_valid = 3'b001;
    cfg_we = 1'b1;
    cfg_wdata = 2'b10;
    step();
    cfg_we = 1'b0;
    chk("ovfen_opA", 128'(rnd_ovfen), 128'(0));
    bus.req_data[0 +: IN_W] = rand_bundle();
    step();
    chk("ovfen_opB", 128'(rnd_ovfen), 128'(1));
    bus.req_valid = '0;
    repeat (4) step();

    // reset while both stages hold ops, then requester 0 must win first
    bus.req_valid = 3'b111;
    bus.out_ready = 1'b0;
    repeat (3) begin rand_data(); step(); end
    do_reset();
    bus.req_valid = 3'b111;
    bus.out_ready = 1'b1;
    rand_data();
    step();
    bus.req_valid = '0;
    repeat (3) step();

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      bus.req_valid = N'($urandom);
      rand_data();
      bus.out_ready = ($urandom % 4) != 0;
      cfg_we = ($urandom % 16) == 0;
      cfg_wdata = 2'($urandom);
      step();
    end
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    cfg_we = 1'b0;
    repeat (4) step();
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
